cr_clint_mhart: RTL and testbench

//  Parametrised multi-hart core-local interruptor: per-hart msip/mtimecmp, shared 64-bit mtime.

---
 rtl/cr_clint_mhart.sv | 170 +++++++++++++++++
 tb/tb_cr_clint_mhart.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_clint_mhart.sv
// Multi-hart CLINT: per-hart msip/mtimecmp, shared 64-bit mtime, one-cycle read latency.
// Define CLINT_MTIME_INTERNAL_EN for an internal prescaled mtime counter; otherwise mtime is
// taken from sysio_clint_mtime.
module cr_clint_mhart #(
  parameter int unsigned NUM_HART = 2,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic                tcipif_clint_sel,
  input  logic                tcipif_clint_write,
  input  logic [15:0]         tcipif_clint_addr,
  input  logic [31:0]         tcipif_clint_wdata,
  input  logic [1:0]          cpu_clint_mode,
  input  logic [NUM_HART-1:0] sysio_clint_me_int,
  input  logic [63:0]         sysio_clint_mtime,
  output logic                clint_tcipif_cmplt,
  output logic [31:0]         clint_tcipif_rdata,
  output logic [NUM_HART-1:0] clint_cpu_ms_int,
  output logic [NUM_HART-1:0] clint_cpu_mt_int,
  output logic [NUM_HART-1:0] clint_cpu_me_int
);

  typedef enum logic [0:0] {
    StIdle,
    StResp
  } acc_state_e;

  acc_state_e state_q, state_d;

  logic                machine;
  logic                wr_en;
  logic                is_msip;
  logic                is_cmp;
  logic                is_mtime;
  logic                addr_hi;
  logic [2:0]          msip_h;
  logic [2:0]          cmp_h;
  logic [63:0]         mtime;
  logic [NUM_HART-1:0] msip_q, msip_d;
  logic [NUM_HART-1:0] mt_q, mt_d;
  logic [NUM_HART-1:0] me_q;
  logic [63:0]         cmp_q [NUM_HART];
  logic [63:0]         cmp_d [NUM_HART];
  logic [31:0]         rdata_q, rdata_d;

  logic unused_addr;
  assign unused_addr = ^tcipif_clint_addr[1:0];

  assign machine  = cpu_clint_mode == 2'b11;
  assign wr_en    = tcipif_clint_sel & tcipif_clint_write & machine;
  assign is_msip  = tcipif_clint_addr[15:5] == 11'h000;
  assign msip_h   = tcipif_clint_addr[4:2];
  assign is_cmp   = tcipif_clint_addr[15:6] == 10'h100;
  assign cmp_h    = tcipif_clint_addr[5:3];
  assign is_mtime = tcipif_clint_addr[15:3] == 13'h17ff;
  assign addr_hi  = tcipif_clint_addr[2];

`ifdef CLINT_MTIME_INTERNAL_EN
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);

  logic [63:0]    mtime_q, mtime_d;
  logic [PsW-1:0] ps_q, ps_d;

  logic unused_mtime;
  assign unused_mtime = ^sysio_clint_mtime;

  // A software write to either half restarts the prescaler and swallows that cycle's tick.
  always_comb begin
    mtime_d = mtime_q;
    ps_d    = ps_q;
    if (wr_en && is_mtime) begin
      if (addr_hi) begin
        mtime_d[63:32] = tcipif_clint_wdata;
      end else begin
        mtime_d[31:0] = tcipif_clint_wdata;
      end
      ps_d = '0;
    end else if (ps_q == PsMax) begin
      ps_d    = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      ps_d = ps_q + PsW'(1);
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      mtime_q <= '0;
      ps_q    <= '0;
    end else begin
      mtime_q <= mtime_d;
      ps_q    <= ps_d;
    end
  end

  assign mtime = mtime_q;
`else
  assign mtime = sysio_clint_mtime;
`endif

  always_comb begin
    msip_d = msip_q;
    cmp_d  = cmp_q;
    mt_d   = '0;
    for (int unsigned i = 0; i < NUM_HART; i++) begin
      if (wr_en && is_msip && msip_h == 3'(i)) begin
        msip_d[i] = tcipif_clint_wdata[0];
      end
      if (wr_en && is_cmp && cmp_h == 3'(i)) begin
        if (addr_hi) begin
          cmp_d[i][63:32] = tcipif_clint_wdata;
        end else begin
          cmp_d[i][31:0] = tcipif_clint_wdata;
        end
      end
      mt_d[i] = mtime >= cmp_q[i];
    end
  end

  // Read mux sees pre-write state; unimplemented harts fall out of the loop and read zero.
  always_comb begin
    rdata_d = '0;
    if (tcipif_clint_sel && machine) begin
      for (int unsigned i = 0; i < NUM_HART; i++) begin
        if (is_msip && msip_h == 3'(i)) begin
          rdata_d = {31'd0, msip_q[i]};
        end
        if (is_cmp && cmp_h == 3'(i)) begin
          rdata_d = addr_hi ? cmp_q[i][63:32] : cmp_q[i][31:0];
        end
      end
      if (is_mtime) begin
        rdata_d = addr_hi ? mtime[63:32] : mtime[31:0];
      end
    end
  end

  always_comb begin
    state_d = tcipif_clint_sel ? StResp : StIdle;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q <= StIdle;
      rdata_q <= '0;
      msip_q  <= '0;
      mt_q    <= '0;
      me_q    <= '0;
      for (int unsigned i = 0; i < NUM_HART; i++) begin
        cmp_q[i] <= '1;
      end
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      msip_q  <= msip_d;
      mt_q    <= mt_d;
      me_q    <= sysio_clint_me_int;
      cmp_q   <= cmp_d;
    end
  end

  assign clint_tcipif_cmplt = state_q == StResp;
  assign clint_tcipif_rdata = (state_q == StResp) ? rdata_q : '0;
  assign clint_cpu_ms_int   = msip_q;
  assign clint_cpu_mt_int   = mt_q;
  assign clint_cpu_me_int   = me_q;

endmodule

// File: tb/tb_cr_clint_mhart.sv
// Bench for cr_clint_mhart: register-map model checked every cycle plus directed literal checks.
// Follows CLINT_MTIME_INTERNAL_EN like the design.
module tb_cr_clint_mhart;

  localparam int unsigned NH = 2;
  localparam int unsigned PS = 4;

  logic          clk = 1'b0;
  logic          cpurst;
  logic          sel;
  logic          write;
  logic [15:0]   addr;
  logic [31:0]   wdata;
  logic [1:0]    mode;
  logic [NH-1:0] me_in;
  logic [63:0]   sys_mtime;
  logic          cmplt;
  logic [31:0]   rdata;
  logic [NH-1:0] ms_int;
  logic [NH-1:0] mt_int;
  logic [NH-1:0] me_int;

  int vectors = 0;
  int fails   = 0;

  cr_clint_mhart #(
    .NUM_HART(NH),
    .PRESCALE(PS)
  ) dut (
    .forever_cpuclk    (clk),
    .cpurst            (cpurst),
    .tcipif_clint_sel  (sel),
    .tcipif_clint_write(write),
    .tcipif_clint_addr (addr),
    .tcipif_clint_wdata(wdata),
    .cpu_clint_mode    (mode),
    .sysio_clint_me_int(me_in),
    .sysio_clint_mtime (sys_mtime),
    .clint_tcipif_cmplt(cmplt),
    .clint_tcipif_rdata(rdata),
    .clint_cpu_ms_int  (ms_int),
    .clint_cpu_mt_int  (mt_int),
    .clint_cpu_me_int  (me_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Register-level model: state of each architectural register, updated per accepted access.
  logic [NH-1:0] m_msip;
  logic [63:0]   m_cmp [NH];
  logic [63:0]   m_mtime;
  int            m_ps;
  logic          e_cmplt;
  logic [31:0]   e_rdata;
  logic [NH-1:0] e_ms, e_mt, e_me;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin : model
    logic [63:0] t;
    int          a;
    int          h;
    bit          t_wr;
    if (cpurst) begin
      chk_en  = 1'b1;
      m_msip  = '0;
      for (int i = 0; i < NH; i++) m_cmp[i] = '1;
      m_mtime = '0;
      m_ps    = 0;
      e_cmplt = 1'b0;
      e_rdata = '0;
      e_ms    = '0;
      e_mt    = '0;
      e_me    = '0;
    end else begin
`ifdef CLINT_MTIME_INTERNAL_EN
      t = m_mtime;
`else
      t = sys_mtime;
`endif
      for (int i = 0; i < NH; i++) e_mt[i] = (t >= m_cmp[i]);
      e_me    = me_in;
      e_cmplt = sel;
      e_rdata = '0;
      t_wr    = 1'b0;
      a       = int'(addr) & 'hfffc;
      if (sel && mode == 2'b11) begin
        if (a < 4 * NH) begin
          e_rdata = {31'd0, m_msip[a/4]};
          if (write) m_msip[a/4] = wdata[0];
        end else if (a >= 'h4000 && a < 'h4000 + 8 * NH) begin
          h = (a - 'h4000) / 8;
          e_rdata = (a % 8 == 4) ? m_cmp[h][63:32] : m_cmp[h][31:0];
          if (write && a % 8 == 4) m_cmp[h][63:32] = wdata;
          else if (write) m_cmp[h][31:0] = wdata;
        end else if (a == 'hbff8 || a == 'hbffc) begin
          e_rdata = (a == 'hbffc) ? t[63:32] : t[31:0];
          if (write) begin
            t_wr = 1'b1;
            if (a == 'hbffc) m_mtime[63:32] = wdata;
            else m_mtime[31:0] = wdata;
          end
        end
      end
`ifdef CLINT_MTIME_INTERNAL_EN
      if (t_wr) begin
        m_ps = 0;
      end else if (m_ps == PS - 1) begin
        m_ps    = 0;
        m_mtime = m_mtime + 64'd1;
      end else begin
        m_ps++;
      end
`endif
      e_ms = m_msip;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmplt", 64'(cmplt), 64'(e_cmplt));
      check("rdata", 64'(rdata), 64'(e_rdata));
      check("ms_int", 64'(ms_int), 64'(e_ms));
      check("mt_int", 64'(mt_int), 64'(e_mt));
      check("me_int", 64'(me_int), 64'(e_me));
    end
  end

  task automatic drive(input logic s, input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [1:0] m);
    @(negedge clk);
    sel   = s;
    write = w;
    addr  = a;
    wdata = d;
    mode  = m;
  endtask

  // Issue one access and land just after the edge that samples it.
  task automatic access(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [1:0] m);
    drive(1'b1, w, a, d, m);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 2'b11);
    @(posedge clk);
    #1;
  endtask

  initial begin
    cpurst    = 1'b1;
    sel       = 1'b0;
    write     = 1'b0;
    addr      = '0;
    wdata     = '0;
    mode      = 2'b11;
    me_in     = '0;
    sys_mtime = '0;
    repeat (3) @(negedge clk);
    cpurst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_cmplt", 64'(cmplt), 64'd0);
    check("rst_ints", 64'({ms_int, mt_int, me_int}), 64'd0);

    access(1'b0, 16'h4000, 32'h0, 2'b11);
    check("cmp0_lo_cmplt", 64'(cmplt), 64'd1);
    check("cmp0_lo", 64'(rdata), 64'hffff_ffff);
    access(1'b0, 16'h4004, 32'h0, 2'b11);
    check("cmp0_hi", 64'(rdata), 64'hffff_ffff);
    idle_cycle();
    check("idle_cmplt", 64'(cmplt), 64'd0);
    check("idle_rdata", 64'(rdata), 64'd0);

    access(1'b1, 16'h0004, 32'h1, 2'b11);
    check("msip1_set", 64'(ms_int), 64'b10);
    access(1'b1, 16'h0004, 32'h0, 2'b00);
    check("user_wr_cmplt", 64'(cmplt), 64'd1);
    check("user_wr_ms", 64'(ms_int), 64'b10);
    access(1'b0, 16'h0004, 32'h0, 2'b01);
    check("user_rd", 64'(rdata), 64'd0);
    access(1'b0, 16'h0006, 32'h0, 2'b11);
    check("msip1_rd", 64'(rdata), 64'd1);

    // Back-to-back: read, write, read of msip[0].
    access(1'b0, 16'h0000, 32'h0, 2'b11);
    check("b2b_rd0", 64'(rdata), 64'd0);
    access(1'b1, 16'h0000, 32'hffff_fffe, 2'b11);
    check("b2b_wr", 64'(rdata), 64'd0);
    access(1'b0, 16'h0000, 32'h0, 2'b11);
    check("b2b_rd1", 64'(rdata), 64'd0);
    access(1'b1, 16'h0000, 32'h1, 2'b11);
    access(1'b0, 16'h0000, 32'h0, 2'b11);
    check("b2b_rd2", 64'(rdata), 64'd1);
    check("ms_both", 64'(ms_int), 64'b11);

    access(1'b0, 16'h4000 + 16'(8 * NH), 32'h0, 2'b11);
    check("oob_cmp", 64'(rdata), 64'd0);
    access(1'b1, 16'h0000 + 16'(4 * NH), 32'h0, 2'b11);
    access(1'b0, 16'h0000 + 16'(4 * NH), 32'h0, 2'b11);
    check("oob_msip", 64'(rdata), 64'd0);
    check("oob_cmplt", 64'(cmplt), 64'd1);
    access(1'b0, 16'h8000, 32'h0, 2'b11);
    check("oob_8000", 64'(rdata), 64'd0);
    check("oob_ms", 64'(ms_int), 64'b11);

    // mtimecmp[1] = 100 written lo first, so it is briefly 0xffffffff_00000064.
    access(1'b1, 16'h4008, 32'd100, 2'b11);
    access(1'b0, 16'h4008, 32'h0, 2'b11);
    check("cmp1_lo", 64'(rdata), 64'd100);
    access(1'b1, 16'h400c, 32'd0, 2'b11);

`ifdef CLINT_MTIME_INTERNAL_EN
    access(1'b1, 16'h4000, 32'd10, 2'b11);
    access(1'b1, 16'h4004, 32'd0, 2'b11);
    access(1'b1, 16'hbff8, 32'd0, 2'b11);
    drive(1'b1, 1'b1, 16'hbffc, 32'd0, 2'b11);
    @(posedge clk);
    #1;
    sel = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("mt0_before", 64'(mt_int[0]), 64'd0);
    @(posedge clk);
    #1;
    check("mt0_rise", 64'(mt_int[0]), 64'd1);
    access(1'b1, 16'hbff8, 32'hffff_ffff, 2'b11);
    access(1'b1, 16'hbffc, 32'hffff_ffff, 2'b11);
    repeat (PS) idle_cycle();
    access(1'b0, 16'hbff8, 32'h0, 2'b11);
    check("wrap_lo", 64'(rdata), 64'd0);
    access(1'b0, 16'hbffc, 32'h0, 2'b11);
    check("wrap_hi", 64'(rdata), 64'd0);
`else
    drive(1'b0, 1'b0, 16'h0, 32'h0, 2'b11);
    sys_mtime = 64'd99;
    @(posedge clk);
    #1;
    check("mt_99", 64'(mt_int), 64'b00);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 2'b11);
    sys_mtime = 64'd100;
    @(posedge clk);
    #1;
    check("mt_100", 64'(mt_int), 64'b10);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 2'b11);
    sys_mtime = '1;
    @(posedge clk);
    #1;
    check("mt_max", 64'(mt_int), 64'b11);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 2'b11);
    sys_mtime = 64'h1234_5678_9abc_def0;
    access(1'b0, 16'hbff8, 32'h0, 2'b11);
    check("mtime_lo", 64'(rdata), 64'h9abc_def0);
    access(1'b1, 16'hbffc, 32'h0, 2'b11);
    access(1'b0, 16'hbffc, 32'h0, 2'b11);
    check("mtime_hi", 64'(rdata), 64'h1234_5678);
`endif

    drive(1'b0, 1'b0, 16'h0, 32'h0, 2'b11);
    me_in = 2'b01;
    @(posedge clk);
    #1;
    check("me_int", 64'(me_int), 64'b01);

    // Reset arriving with an access in flight drops it.
    drive(1'b1, 1'b0, 16'h4008, 32'h0, 2'b11);
    cpurst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_drop", 64'(cmplt), 64'd0);
    check("rst_ms", 64'(ms_int), 64'd0);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 2'b11);
    cpurst = 1'b0;
    access(1'b0, 16'h400c, 32'h0, 2'b11);
    check("rst_cmp1", 64'(rdata), 64'hffff_ffff);
    idle_cycle();
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
